// File: rtl/boot_pkg.sv
// Shared constants for the UART boot loader: loader/receiver state encodings,
// byte-lane layout of an instruction word and the bit-period calculation.
package boot_pkg;

    typedef logic [2:0] boot_state_t;
    typedef logic [1:0] rx_state_t;

    localparam boot_state_t ST_WAIT_COUNT = 3'd0;
    localparam boot_state_t ST_RECV_DATA  = 3'd1;
    localparam boot_state_t ST_RECV_CSUM  = 3'd2;
    localparam boot_state_t ST_DONE       = 3'd3;
    localparam boot_state_t ST_ERROR      = 3'd4;

    localparam rx_state_t RX_IDLE  = 2'd0;
    localparam rx_state_t RX_START = 2'd1;
    localparam rx_state_t RX_DATA  = 2'd2;
    localparam rx_state_t RX_STOP  = 2'd3;

    localparam int        BYTES_PER_WORD = 4;
    localparam int        BYTE_W         = 8;
    localparam logic [1:0] LAST_LANE     = 2'(BYTES_PER_WORD - 1);

    // Rounded to the nearest clock so the sample point drifts least over a byte.
    function automatic int clks_per_bit(input int clk_hz, input int baud);
        return (clk_hz + baud / 2) / baud;
    endfunction

endpackage

// File: rtl/uart_rx.sv
// 8N1 UART receiver: two-flop synchroniser, falling-edge start detect,
// mid-bit sampling with a down-counter, one-cycle rx_valid / frame_err pulses.
module uart_rx
    import boot_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rxd,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       frame_err
);

    localparam int CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] BIT_LOAD  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    logic [1:0]       sync_q, sync_d;
    logic             prev_q, prev_d;
    rx_state_t        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_q, bit_d;
    logic [7:0]       shift_q, shift_d;
    logic [7:0]       data_q, data_d;
    logic             valid_q, valid_d;
    logic             ferr_q, ferr_d;
    logic             rxs;

    assign rxs = sync_q[1];

    always_comb begin
        sync_d  = {sync_q[0], rxd};
        prev_d  = rxs;
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        data_d  = data_q;
        valid_d = 1'b0;
        ferr_d  = 1'b0;

        case (state_q)
            RX_IDLE: begin
                if (prev_q && !rxs) begin
                    state_d = RX_START;
                    cnt_d   = HALF_LOAD;
                end
            end
            RX_START: begin
                if (cnt_q == '0) begin
                    // Line back high at mid start bit: treat as a glitch.
                    if (rxs) begin
                        state_d = RX_IDLE;
                    end else begin
                        state_d = RX_DATA;
                        cnt_d   = BIT_LOAD;
                        bit_d   = 3'd0;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            RX_DATA: begin
                if (cnt_q == '0) begin
                    shift_d = {rxs, shift_q[7:1]};
                    cnt_d   = BIT_LOAD;
                    if (bit_q == 3'd7) begin
                        state_d = RX_STOP;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            default: begin
                if (cnt_q == '0) begin
                    state_d = RX_IDLE;
                    if (rxs) begin
                        valid_d = 1'b1;
                        data_d  = shift_q;
                    end else begin
                        ferr_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
        endcase
    end

    // Synchroniser resets to the idle-high level so reset release is not seen as a start edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q  <= 2'b11;
            prev_q  <= 1'b1;
            state_q <= RX_IDLE;
            cnt_q   <= '0;
            bit_q   <= 3'd0;
            shift_q <= 8'd0;
            data_q  <= 8'd0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            prev_q  <= prev_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
        end
    end

    assign rx_data   = data_q;
    assign rx_valid  = valid_q;
    assign frame_err = ferr_q;

endmodule

// File: rtl/uart_boot_loader.sv
// Loads a COUNT / data / XOR-checksum frame from the UART into instruction memory
// and keeps the CPU in reset until a checksum-verified image has been written.
module uart_boot_loader
    import boot_pkg::*;
#(
    parameter int CLK_HZ       = 50000000,
    parameter int BAUD         = 115200,
    parameter int ADDR_W       = 8,
    parameter int TIMEOUT_CLKS = 5000000
) (
    input  logic              MAX10_CLK1_50,
    input  logic              reset,
    input  logic              uart_rxd,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              cpu_reset,
    output logic              loading,
    output logic              load_error,
    output logic [ADDR_W:0]   words_loaded
);

    localparam int TMO_W = $clog2(TIMEOUT_CLKS + 1);
    localparam logic [TMO_W-1:0]  TMO_LOAD = TMO_W'(TIMEOUT_CLKS);
    localparam logic [TMO_W-1:0]  TMO_ONE  = TMO_W'(1);
    localparam logic [ADDR_W:0]   CNT_ZERO_MEANS = (ADDR_W + 1)'(256);

    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_err;

    uart_rx #(
        .CLKS_PER_BIT(clks_per_bit(CLK_HZ, BAUD))
    ) u_rx (
        .clk      (MAX10_CLK1_50),
        .reset    (reset),
        .rxd      (uart_rxd),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .frame_err(frame_err)
    );

    boot_state_t       state_q, state_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic [23:0]       word_q, word_d;
    logic [1:0]        lane_q, lane_d;
    logic [7:0]        acc_q, acc_d;
    logic [TMO_W-1:0]  tmo_q, tmo_d;
    logic              imem_we_q, imem_we_d;
    logic [ADDR_W-1:0] imem_addr_q, imem_addr_d;
    logic [31:0]       imem_wdata_q, imem_wdata_d;
    logic              cpu_reset_q, cpu_reset_d;
    logic              loading_q, loading_d;
    logic              load_error_q, load_error_d;
    logic [ADDR_W:0]   words_loaded_q, words_loaded_d;
    logic [ADDR_W:0]   words_inc;
    logic              go_err;

    assign words_inc = words_loaded_q + (ADDR_W + 1)'(1);

    always_comb begin
        state_d        = state_q;
        count_d        = count_q;
        word_d         = word_q;
        lane_d         = lane_q;
        acc_d          = acc_q;
        tmo_d          = tmo_q;
        imem_we_d      = 1'b0;
        imem_addr_d    = imem_addr_q;
        imem_wdata_d   = imem_wdata_q;
        cpu_reset_d    = cpu_reset_q;
        loading_d      = loading_q;
        load_error_d   = load_error_q;
        words_loaded_d = words_loaded_q;
        go_err         = 1'b0;

        case (state_q)
            ST_WAIT_COUNT, ST_ERROR: begin
                if (rx_valid) begin
                    count_d        = (rx_data == 8'd0) ? CNT_ZERO_MEANS : (ADDR_W + 1)'(rx_data);
                    loading_d      = 1'b1;
                    load_error_d   = 1'b0;
                    words_loaded_d = '0;
                    acc_d          = 8'd0;
                    lane_d         = 2'd0;
                    tmo_d          = TMO_LOAD;
                    state_d        = ST_RECV_DATA;
                end
            end
            ST_RECV_DATA: begin
                if (rx_valid) begin
                    word_d = {rx_data, word_q[23:8]};
                    acc_d  = acc_q ^ rx_data;
                    tmo_d  = TMO_LOAD;
                    lane_d = lane_q + 2'd1;
                    if (lane_q == LAST_LANE) begin
                        imem_we_d      = 1'b1;
                        imem_addr_d    = words_loaded_q[ADDR_W-1:0];
                        imem_wdata_d   = {rx_data, word_q};
                        words_loaded_d = words_inc;
                        if (words_inc == count_q) begin
                            state_d = ST_RECV_CSUM;
                        end
                    end
                end else if (tmo_q == TMO_ONE) begin
                    go_err = 1'b1;
                end else begin
                    tmo_d = tmo_q - TMO_ONE;
                end
            end
            ST_RECV_CSUM: begin
                if (rx_valid) begin
                    if (rx_data == acc_q) begin
                        state_d     = ST_DONE;
                        cpu_reset_d = 1'b0;
                        loading_d   = 1'b0;
                    end else begin
                        go_err = 1'b1;
                    end
                end else if (tmo_q == TMO_ONE) begin
                    go_err = 1'b1;
                end else begin
                    tmo_d = tmo_q - TMO_ONE;
                end
            end
            ST_DONE: begin
            end
            default: begin
                go_err = 1'b1;
            end
        endcase

        // A completed load is final until reset; line noise must not reassert cpu_reset.
        if (frame_err && (state_q != ST_DONE)) begin
            go_err = 1'b1;
        end

        if (go_err) begin
            state_d      = ST_ERROR;
            load_error_d = 1'b1;
            loading_d    = 1'b0;
            cpu_reset_d  = 1'b1;
        end
    end

    always_ff @(posedge MAX10_CLK1_50 or posedge reset) begin
        if (reset) begin
            state_q        <= ST_WAIT_COUNT;
            count_q        <= '0;
            word_q         <= 24'd0;
            lane_q         <= 2'd0;
            acc_q          <= 8'd0;
            tmo_q          <= '0;
            imem_we_q      <= 1'b0;
            imem_addr_q    <= '0;
            imem_wdata_q   <= 32'd0;
            cpu_reset_q    <= 1'b1;
            loading_q      <= 1'b0;
            load_error_q   <= 1'b0;
            words_loaded_q <= '0;
        end else begin
            state_q        <= state_d;
            count_q        <= count_d;
            word_q         <= word_d;
            lane_q         <= lane_d;
            acc_q          <= acc_d;
            tmo_q          <= tmo_d;
            imem_we_q      <= imem_we_d;
            imem_addr_q    <= imem_addr_d;
            imem_wdata_q   <= imem_wdata_d;
            cpu_reset_q    <= cpu_reset_d;
            loading_q      <= loading_d;
            load_error_q   <= load_error_d;
            words_loaded_q <= words_loaded_d;
        end
    end

    assign imem_we      = imem_we_q;
    assign imem_addr    = imem_addr_q;
    assign imem_wdata   = imem_wdata_q;
    assign cpu_reset    = cpu_reset_q;
    assign loading      = loading_q;
    assign load_error   = load_error_q;
    assign words_loaded = words_loaded_q;

endmodule

// File: doc/uart_boot_loader.md
Name: uart_boot_loader

Overview:
- Upstream of the CPU. Receives a program image over the DE-10 Lite UART pin and writes it word-by-word into the 256x32 instruction ROM through that memory's write port.
- Holds the CPU in reset until a complete, checksum-verified image has been written, then releases it.
- Lets the team reload programs without resynthesising the ROM init file.

Parameters:
- CLK_HZ, 50000000, input clock frequency in Hz.
- BAUD, 115200, UART bit rate.
- ADDR_W, 8, instruction memory address width (256 words).
- TIMEOUT_CLKS, 5000000, maximum idle clocks allowed between bytes inside a frame (100 ms).

Ports:
- MAX10_CLK1_50  in  1  system clock, 50 MHz.
- reset  in  1  asynchronous, active-high reset.
- uart_rxd  in  1  asynchronous serial input; idles high.
- imem_we  out  1  instruction-memory write strobe, one cycle per word.
- imem_addr  out  ADDR_W  word address for the write.
- imem_wdata  out  32  word data for the write.
- cpu_reset  out  1  held high while loading or after a failed load; low once a valid image is written.
- loading  out  1  high while a frame is in progress.
- load_error  out  1  sticky error flag; cleared when a new frame starts.
- words_loaded  out  ADDR_W+1  number of words written in the current or last frame.

Behaviour:
- Interface: one clock, MAX10_CLK1_50. reset is asynchronous and active-high.
- Reset values: cpu_reset=1, imem_we=0, imem_addr=0, imem_wdata=0, loading=0, load_error=0, words_loaded=0, FSM=WAIT_COUNT.
- RX synchroniser: uart_rxd passes through a 2-flop synchroniser.
- Bit period: CLKS_PER_BIT = (CLK_HZ + BAUD/2) / BAUD, which is 434 at the defaults.
- Start bit: a falling edge starts the receiver, which re-samples at CLKS_PER_BIT/2.
  - If the line is high at that sample, it is a glitch: return to idle and emit no byte.
- Data and stop bits: 8 data bits are sampled at mid-bit, LSB first. The stop bit is sampled at mid-bit.
  - Stop bit = 1: rx_valid pulses for one cycle with rx_data.
  - Stop bit = 0: frame_err pulses for one cycle and no byte is delivered.
- Frame format: COUNT byte (0 means 256 words), then 4*N data bytes little-endian (byte k fills bits [8k+7:8k]), then one CSUM byte equal to the XOR of all data bytes (COUNT excluded).
- FSM states:
  - WAIT_COUNT: on rx_valid, latch N, set loading=1, load_error=0, words_loaded=0, clear the XOR accumulator, go to RECV_DATA.
  - RECV_DATA: each rx_valid shifts the byte into the word assembler and XORs it into the accumulator.
    - On the 4th byte: in the next cycle imem_we=1 for exactly one cycle with imem_addr = word index and the assembled word on imem_wdata; words_loaded increments in the same cycle.
    - After word N-1, go to RECV_CSUM.
    - imem_addr is ADDR_W bits, so with N=256 the last write is to 255 and the address does not wrap to 0 within the frame.
  - RECV_CSUM: on rx_valid, compare with the accumulator.
    - Match: go to DONE; cpu_reset falls in the cycle after rx_valid; loading=0.
    - Mismatch: go to ERROR.
  - DONE: cpu_reset=0. All further RX activity is ignored until reset.
  - ERROR: load_error=1, cpu_reset=1, loading=0. The next rx_valid is treated as a COUNT byte (same actions as WAIT_COUNT).
- Error triggers: frame_err in any state other than DONE goes to ERROR. In RECV_DATA or RECV_CSUM, an idle-timeout counter (reset on every rx_valid) reaching TIMEOUT_CLKS goes to ERROR.
- Partial writes: words already written before an error stay in memory. No erase is performed.
- Reset mid-frame: all state returns to reset values immediately (asynchronous). The receiver abandons the current byte.
- Simultaneous events: rx_valid and timeout expiry in the same cycle give rx_valid priority and the counter clears. rx_valid and imem_we cannot collide, because a byte takes at least 10 bit periods.

Decomposition:
- Shared package/include boot_pkg:
  - FSM state encoding (WAIT_COUNT, RECV_DATA, RECV_CSUM, DONE, ERROR).
  - CLKS_PER_BIT computation function.
  - Byte-lane constants.
- Sub-module uart_rx (ports: clk, reset, rxd, rx_data[7:0], rx_valid, frame_err) contains the synchroniser, bit counter and sampler.
- The loader FSM, word assembler, XOR accumulator and timeout counter live in uart_boot_loader.

Test Plan:
1. Frame 01 13 00 00 00 csum 13 -> one imem_we pulse, addr 0, wdata 0x00000013, cpu_reset falls after CSUM, words_loaded=1, load_error=0.
2. Frame 02 EF BE AD DE 78 56 34 12 csum 2A -> writes 0xDEADBEEF@0 and 0x12345678@1, each imem_we exactly one cycle, cpu_reset falls, then extra bytes cause no writes.
3. Same frame as scenario 2 with csum 2B -> load_error=1, cpu_reset stays 1. Then the frame from scenario 1 -> load_error clears, addr 0 rewritten, cpu_reset falls.
4. Byte sent with stop bit 0 during RECV_DATA -> ERROR, no write for that word. Also rxd low for 100 clocks then high -> no rx_valid.
5. COUNT 01 plus two data bytes, then idle for TIMEOUT_CLKS+10 clocks -> load_error=1, no imem_we, words_loaded=0.
6. COUNT 00 with 1024 bytes (word i = i) and correct CSUM -> 256 writes at addr 0..255, words_loaded=256, cpu_reset falls. Asserting reset mid-frame at word 100 -> outputs return to reset values at once.
